// File: rtl/io_input_conditioner.sv
// io_input_conditioner
//   Conditions asynchronous input pins for the CPU I/O register block.
//   Per bit: a synchroniser chain, a debounce filter with its own counter,
//   and registered one-cycle rise/fall pulses. stable_o feeds ex_data_i.
//
// Parameters
//   data_width      number of input bits
//   SyncStages      synchroniser depth (2..4)
//   DebounceCycles  consecutive mismatched cycles before stable_o flips (>= 1)
//
// Ports
//   clk_i         system clock
//   reset_i       asynchronous active-high reset
//   raw_i         asynchronous external pins
//   stable_o      debounced levels
//   rise_o        one-cycle pulse per bit on stable 0->1
//   fall_o        one-cycle pulse per bit on stable 1->0
//   changed_o     one-cycle pulse, OR of all rise/fall pulses
//   glitch_clr_i  (IO_COND_GLITCH_CNT_EN) synchronous clear of glitch_cnt_o
//   glitch_cnt_o  (IO_COND_GLITCH_CNT_EN) saturating rejected-glitch count
//
// Build option
//   IO_COND_GLITCH_CNT_EN  adds the rejected-glitch counter and its two ports.
module io_input_conditioner #(
  parameter int data_width     = 8,
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 1000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [data_width-1:0] raw_i,
  output logic [data_width-1:0] stable_o,
  output logic [data_width-1:0] rise_o,
  output logic [data_width-1:0] fall_o,
  output logic                  changed_o
`ifdef IO_COND_GLITCH_CNT_EN
  ,
  input  logic                  glitch_clr_i,
  output logic [15:0]           glitch_cnt_o
`endif
);

  localparam int CountWidth = $clog2(DebounceCycles + 1);
  localparam logic [CountWidth-1:0] LastCount = CountWidth'(DebounceCycles - 1);

  logic [data_width-1:0] r_sync [SyncStages];
  logic [CountWidth-1:0] r_cnt  [data_width];

  logic [data_width-1:0] w_sync;
  logic [data_width-1:0] w_mismatch;
  logic [data_width-1:0] w_flip;

  assign w_sync     = r_sync[SyncStages-1];
  assign w_mismatch = w_sync ^ stable_o;

  // A bit flips when it has already been mismatched for DebounceCycles-1
  // cycles and is still mismatched now.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < data_width; i++) begin
      w_flip[i] = w_mismatch[i] && (r_cnt[i] == LastCount);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int s = 0; s < SyncStages; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= raw_i;
      for (int s = 1; s < SyncStages; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  // Counter clears on a match or on the flip itself, so it never wraps.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < data_width; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < data_width; i++) begin
        if (!w_mismatch[i] || w_flip[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // After a flip the new stable value equals w_sync, so the direction of
  // the pulse is simply the synchronised level of that bit.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stable_o  <= '0;
      rise_o    <= '0;
      fall_o    <= '0;
      changed_o <= 1'b0;
    end else begin
      stable_o  <= stable_o ^ w_flip;
      rise_o    <= w_flip & w_sync;
      fall_o    <= w_flip & ~w_sync;
      changed_o <= |w_flip;
    end
  end

`ifdef IO_COND_GLITCH_CNT_EN
  logic [data_width-1:0] w_glitch_evt;
  logic [16:0]           w_glitch_sum;
  logic [15:0]           r_glitch_cnt;

  // A glitch is a mismatch run that ended before reaching a flip.
  always_comb begin
    w_glitch_evt = '0;
    w_glitch_sum = {1'b0, r_glitch_cnt};
    for (int i = 0; i < data_width; i++) begin
      w_glitch_evt[i] = (r_cnt[i] != '0) && !w_mismatch[i];
      w_glitch_sum    = w_glitch_sum + 17'(w_glitch_evt[i]);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_glitch_cnt <= '0;
    end else if (glitch_clr_i) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch_sum[16]) begin
      r_glitch_cnt <= 16'hFFFF;
    end else begin
      r_glitch_cnt <= w_glitch_sum[15:0];
    end
  end

  assign glitch_cnt_o = r_glitch_cnt;
`else
  // No glitch statistics in this build.
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
module tb_io_input_conditioner;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] raw_a;
  logic [7:0] raw_b;
  logic [7:0] stable_a, rise_a, fall_a;
  logic [7:0] stable_b, rise_b, fall_b;
  logic       changed_a, changed_b;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef IO_COND_GLITCH_CNT_EN
  logic        glitch_clr;
  logic [15:0] glitch_cnt_a, glitch_cnt_b;
`endif

  always #5 clk_i = ~clk_i;

  io_input_conditioner #(.data_width(8), .SyncStages(2), .DebounceCycles(4)) u_dut_a (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .raw_i     (raw_a),
    .stable_o  (stable_a),
    .rise_o    (rise_a),
    .fall_o    (fall_a),
    .changed_o (changed_a)
`ifdef IO_COND_GLITCH_CNT_EN
    ,
    .glitch_clr_i (glitch_clr),
    .glitch_cnt_o (glitch_cnt_a)
`endif
  );

  io_input_conditioner #(.data_width(8), .SyncStages(2), .DebounceCycles(1)) u_dut_b (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .raw_i     (raw_b),
    .stable_o  (stable_b),
    .rise_o    (rise_b),
    .fall_o    (fall_b),
    .changed_o (changed_b)
`ifdef IO_COND_GLITCH_CNT_EN
    ,
    .glitch_clr_i (glitch_clr),
    .glitch_cnt_o (glitch_cnt_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any_pulse;
    logic [15:0] g_before;
    int cyc;

    reset_i = 1'b1;
    raw_a   = 8'h00;
    raw_b   = 8'h00;
`ifdef IO_COND_GLITCH_CNT_EN
    glitch_clr = 1'b0;
`endif
    #23;
    check("reset_stable_a", stable_a, 8'h00);
    check("reset_changed_a", changed_a, 1'b0);
    check("reset_stable_b", stable_b, 8'h00);
`ifdef IO_COND_GLITCH_CNT_EN
    check("reset_glitch_cnt", glitch_cnt_a, 16'h0000);
`endif
    @(negedge clk_i);
    reset_i = 1'b0;

    // Bring stable to A5, then interrupt an FF debounce with reset.
    raw_a = 8'hA5;
    tick(5);
    check("pre_a5_edge5", stable_a, 8'h00);
    tick(1);
    check("pre_a5_stable", stable_a, 8'hA5);
    check("pre_a5_rise", rise_a, 8'hA5);
    @(negedge clk_i);
    raw_a = 8'hFF;
    tick(4);
    #2;
    reset_i = 1'b1;
    #1;
    check("async_rst_stable", stable_a, 8'h00);
    check("async_rst_rise", rise_a, 8'h00);
    check("async_rst_changed", changed_a, 1'b0);
    @(negedge clk_i);
    reset_i = 1'b0;
    tick(1);
    check("release_edge_stable", stable_a, 8'h00);
    tick(4);
    check("post_rst_edge5", stable_a, 8'h00);
    tick(1);
    check("post_rst_edge6_stable", stable_a, 8'hFF);
    check("post_rst_edge6_rise", rise_a, 8'hFF);
    check("post_rst_edge6_changed", changed_a, 1'b1);
    tick(1);
    check("post_rst_edge7_rise", rise_a, 8'h00);
    check("post_rst_edge7_changed", changed_a, 1'b0);

    // All bits fall together, then single-bit latency both ways.
    @(negedge clk_i);
    raw_a = 8'h00;
    tick(6);
    check("ff_to_00_stable", stable_a, 8'h00);
    check("ff_to_00_fall", fall_a, 8'hFF);
    check("ff_to_00_rise", rise_a, 8'h00);
    @(negedge clk_i);
    raw_a = 8'h01;
    tick(5);
    check("lat_rise_edge5", stable_a, 8'h00);
    tick(1);
    check("lat_rise_edge6", stable_a, 8'h01);
    check("lat_rise_pulse", rise_a, 8'h01);
    check("lat_rise_nofall", fall_a, 8'h00);
    tick(1);
    check("lat_rise_one_cycle", rise_a, 8'h00);
    @(negedge clk_i);
    raw_a = 8'h00;
    tick(5);
    check("lat_fall_edge5", fall_a, 8'h00);
    tick(1);
    check("lat_fall_edge6", fall_a, 8'h01);
    check("lat_fall_stable", stable_a, 8'h00);
    check("lat_fall_changed", changed_a, 1'b1);
    tick(1);

    // Three-cycle glitch on bit 3 is rejected.
`ifdef IO_COND_GLITCH_CNT_EN
    g_before = glitch_cnt_a;
`else
    g_before = 16'h0;
`endif
    @(negedge clk_i);
    raw_a = 8'h08;
    tick(3);
    raw_a = 8'h00;
    any_pulse = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (changed_a || stable_a != 8'h00) any_pulse = 1'b1;
    end
    check("glitch_no_change", any_pulse, 1'b0);
`ifdef IO_COND_GLITCH_CNT_EN
    check("glitch_cnt_plus1", glitch_cnt_a, g_before + 16'd1);
`endif

    // Per-bit independence.
    @(negedge clk_i);
    raw_a = 8'h01;
    tick(2);
    raw_a = 8'h81;
    tick(3);
    check("indep_edge5", rise_a, 8'h00);
    tick(1);
    check("indep_rise0", rise_a, 8'h01);
    tick(1);
    check("indep_gap", rise_a, 8'h00);
    tick(1);
    check("indep_rise7", rise_a, 8'h80);
    check("indep_stable", stable_a, 8'h81);
    @(negedge clk_i);
    raw_a = 8'h00;
    tick(10);
    check("indep_back_to_0", stable_a, 8'h00);
    @(negedge clk_i);
    raw_a = 8'hA5;
    tick(6);
    check("simul_rise", rise_a, 8'hA5);
    check("simul_changed", changed_a, 1'b1);
    tick(1);
    check("simul_one_cycle", rise_a, 8'h00);

    // Continuous toggling never changes stable.
    @(negedge clk_i);
    raw_a = 8'h00;
    tick(10);
    check("toggle_start", stable_a, 8'h00);
    any_pulse = 1'b0;
    for (int k = 0; k < 40; k++) begin
      raw_a = ~raw_a;
      tick(1);
      if (changed_a || stable_a != 8'h00) any_pulse = 1'b1;
    end
    check("toggle_no_change", any_pulse, 1'b0);

`ifdef IO_COND_GLITCH_CNT_EN
    cyc = 0;
    while (glitch_cnt_a != 16'hFFFF && cyc < 20000) begin
      raw_a = ~raw_a;
      tick(1);
      cyc++;
    end
    check("sat_reached", (cyc < 20000), 1'b1);
    for (int k = 0; k < 10; k++) begin
      raw_a = ~raw_a;
      tick(1);
    end
    check("sat_hold", glitch_cnt_a, 16'hFFFF);
    check("sat_stable", stable_a, 8'h00);
    glitch_clr = 1'b1;
    raw_a = ~raw_a;
    tick(1);
    check("clr_first", glitch_cnt_a, 16'h0000);
    raw_a = ~raw_a;
    tick(1);
    check("clr_over_glitch", glitch_cnt_a, 16'h0000);
    glitch_clr = 1'b0;
`else
    cyc = 0;
`endif
    raw_a = 8'h00;
    tick(10);

    // DebounceCycles = 1: no filtering beyond the synchroniser.
    @(negedge clk_i);
    raw_b = 8'h01;
    tick(2);
    check("d1_edge2", stable_b, 8'h00);
    tick(1);
    check("d1_edge3", stable_b, 8'h01);
    check("d1_rise", rise_b, 8'h01);
    tick(3);
    @(negedge clk_i);
    raw_b = 8'h03;
    @(negedge clk_i);
    raw_b = 8'h01;
    tick(1);
    tick(1);
    check("d1_glitch_pass", stable_b, 8'h03);
    check("d1_glitch_rise", rise_b, 8'h02);
    tick(1);
    check("d1_glitch_back", stable_b, 8'h01);
    check("d1_glitch_fall", fall_b, 8'h02);
    check("d1_changed", changed_b, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
- Sits directly upstream of the CPU I/O register block; output stable_o drives that block's ex_data_i.
- Per bit, it synchronises asynchronous raw pins, debounces them, and produces one-cycle rise/fall pulses.
- Result: the I/O block's IRQ logic sees only clean, metastability-free, glitch-filtered levels.

Parameters:
- data_width, 8, number of input bits; matches the I/O block data_width.
- SyncStages, 2, flops in each synchroniser chain; legal range 2..4.
- DebounceCycles, 1000, consecutive mismatched cycles required before stable_o changes; legal minimum 1.
- CountWidth, $clog2(DebounceCycles+1), debounce counter width; derived, not overridden.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  reset; asynchronous, active-high.
- raw_i  input  data_width  asynchronous external pins.
- stable_o  output  data_width  debounced levels; feeds ex_data_i.
- rise_o  output  data_width  one-cycle pulse per bit on stable 0->1.
- fall_o  output  data_width  one-cycle pulse per bit on stable 1->0.
- changed_o  output  1  one-cycle pulse; OR of rise_o | fall_o.

Behaviour:
- Reset: reset_i high immediately clears all of the following to 0, independent of clk_i:
  - synchroniser flops
  - debounce counters
  - stable_o, rise_o, fall_o, changed_o
- Reset takes effect mid-debounce with no completion of the in-flight count. Release is used synchronously, with no output change on the release edge.
- Synchroniser: per bit, a SyncStages-deep flop chain. sync = last stage. No combinational path from raw_i to any output.
- Debounce: independent per bit, each bit with its own CountWidth counter.
  - sync != stable and counter < DebounceCycles-1: counter increments.
  - sync != stable and counter == DebounceCycles-1: stable flips, counter clears to 0.
  - sync == stable: counter clears to 0. A glitch shorter than DebounceCycles cycles is discarded.
- Counter never wraps; maximum value reached is DebounceCycles-1.
- DebounceCycles=1: stable flips on the first mismatched edge, i.e. no filtering beyond the synchroniser.
- Latency: edge 1 is the first clk_i edge that samples a new raw level held steady. stable_o changes at edge SyncStages+DebounceCycles. Example: 6 for SyncStages=2, DebounceCycles=4.
- Edge pulses:
  - rise_o[n] / fall_o[n] are registered and assert on the same edge stable_o[n] changes, for exactly one cycle.
  - rise_o[n] and fall_o[n] are never both high.
  - changed_o is registered with the pulses.
- Multiple bits may flip on the same edge; each bit pulses independently.
- A raw level toggling continuously faster than DebounceCycles never changes stable_o.

Optional Feature:
- Macro: IO_COND_GLITCH_CNT_EN.
- Defined adds two ports:
  - glitch_clr_i  input  1  synchronous clear of glitch_cnt_o.
  - glitch_cnt_o  output  16  rejected-glitch count.
- A glitch event on a bit is: counter != 0 and sync == stable. Each cycle, glitch_cnt_o adds the number of bits with a glitch event that cycle.
- glitch_cnt_o saturates at 16'hFFFF, resets to 0, and glitch_clr_i has priority over increment.
- Undefined: ports absent, no counter logic, all other behaviour identical.

Test Plan:
- Reset/idle: assert reset_i mid-cycle with raw_i=8'hFF and counters mid-count -> all outputs 0 before the next clk_i edge; after release, stable_o=8'hFF at edge SyncStages+DebounceCycles, with rise_o=8'hFF and changed_o=1 for one cycle.
- Latency (SyncStages=2, DebounceCycles=4): raw_i 8'h00->8'h01 -> stable_o=8'h01 exactly at edge 6, rise_o=8'h01 one cycle; then raw_i->8'h00 -> fall_o=8'h01 at edge 6 after that change.
- Glitch rejection: raw_i[3] high for 3 cycles then low (DebounceCycles=4) -> stable_o unchanged, no pulses; with IO_COND_GLITCH_CNT_EN, glitch_cnt_o increments by 1.
- Per-bit independence: raw_i[0] rises at t, raw_i[7] rises at t+2 -> rise_o[0] and rise_o[7] pulse 2 cycles apart; simultaneous 8'h00->8'hA5 -> single rise_o=8'hA5.
- DebounceCycles=1: raw_i step -> stable_o changes at edge SyncStages+1, single-cycle glitch passes through.
- Glitch counter saturation/clear (macro on): preload near 16'hFFFF via repeated glitches -> holds 16'hFFFF; glitch_clr_i asserted with a coincident glitch -> 0 next cycle.
